// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button conditioner.
//   state_e : debounce FSM states
//   phase_e : auto-repeat phase (initial delay vs. steady period)
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    PH_DELAY  = 1'b0,
    PH_PERIOD = 1'b1
  } phase_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    else        return $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear (both flops reset to 0)
//   d     : asynchronous input
//   q     : synchronised output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit a stable level
// plus one-cycle press / release pulses, with optional auto-repeat.
//   CLK100MHZ   : system clock
//   CPU_RESETN  : asynchronous active-low reset
//   btn_in      : raw button, asynchronous to CLK100MHZ
//   btn_level   : debounced level
//   btn_press   : pulse per accepted press and per auto-repeat
//   btn_repeat  : pulse on auto-repeats only
//   btn_release : pulse per accepted release
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_repeat,
  output logic btn_release
);

  localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_EN      = (REPEAT_DELAY != 0);

  // Reject parameter values that would make the counters meaningless.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("btn_conditioner: REPEAT_PERIOD must be >= 1");
  end

  logic btn_s;

  sync_2ff u_sync (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .d     (btn_in),
    .q     (btn_s)
  );

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              repeat_q, repeat_d;
  logic              release_q, release_d;

  logic db_done_c;
  logic rpt_hit_c;

  assign db_done_c = (db_cnt_q == DB_LAST);

  // A repeat only fires while the button is still seen held; a release
  // detected on the same edge suppresses it.
  assign rpt_hit_c = RPT_EN && btn_s && (state_q == ST_HELD) &&
                     (((phase_q == PH_DELAY)  && (rpt_cnt_q == DELAY_LAST)) ||
                      ((phase_q == PH_PERIOD) && (rpt_cnt_q == PERIOD_LAST)));

  // State and output registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_DELAY;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    db_cnt_d  = db_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (db_done_c) begin
          state_d   = ST_HELD;
          rpt_cnt_d = '0;
          phase_d   = PH_DELAY;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d  = ST_DB_RELEASE;
          db_cnt_d = '0;
        end else if (rpt_hit_c) begin
          rpt_cnt_d = '0;
          phase_d   = PH_PERIOD;
        end else if (RPT_EN) begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
      ST_DB_RELEASE: begin
        // Repeat counter is frozen here; a bounce back resumes it as-is.
        if (btn_s) begin
          state_d = ST_HELD;
        end else if (db_done_c) begin
          state_d = ST_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode, registered one edge later with the state change.
  always_comb begin
    level_d   = 1'b0;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_DB_PRESS: begin
        if (btn_s && db_done_c) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      ST_HELD: begin
        level_d = 1'b1;
        if (rpt_hit_c) begin
          press_d  = 1'b1;
          repeat_d = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        level_d = 1'b1;
        if (!btn_s && db_done_c) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_repeat  = repeat_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: two instances (no repeat / repeat),
// expected output events queued by the stimulus, popped by a monitor.
module tb_btn_conditioner;

  localparam int K_UP    = 0;
  localparam int K_DN    = 1;
  localparam int K_PRESS = 2;
  localparam int K_RPT   = 3;
  localparam int K_REL   = 4;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_a, btn_r;
  logic lvl_a, press_a, rpt_a, rel_a;
  logic lvl_r, press_r, rpt_r, rel_r;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  q_a[$];
  ev_t  q_r[$];
  logic prev_a = 1'b0;
  logic prev_r = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_in(btn_a),
    .btn_level(lvl_a), .btn_press(press_a), .btn_repeat(rpt_a), .btn_release(rel_a)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_r (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .btn_in(btn_r),
    .btn_level(lvl_r), .btn_press(press_r), .btn_repeat(rpt_r), .btn_release(rel_r)
  );

  function automatic string kname(input int k);
    case (k)
      K_UP:    return "level_rise";
      K_DN:    return "level_fall";
      K_PRESS: return "press";
      K_RPT:   return "repeat";
      default: return "release";
    endcase
  endfunction

  function automatic void expect_ev(input int inst, input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    if (inst == 0) q_a.push_back(e);
    else           q_r.push_back(e);
  endfunction

  function void got_ev(input int inst, input int k);
    ev_t e;
    int  sz;
    n_cmp++;
    sz = (inst == 0) ? q_a.size() : q_r.size();
    if (sz == 0) begin
      n_err++;
      $display("FAIL unexpected_event inst%0d: got %s at cycle %0d, expected none",
               inst, kname(k), cyc);
      return;
    end
    if (inst == 0) e = q_a.pop_front();
    else           e = q_r.pop_front();
    if (e.kind != k || e.cyc != cyc) begin
      n_err++;
      $display("FAIL event inst%0d: got %s at cycle %0d, expected %s at cycle %0d",
               inst, kname(k), cyc, kname(e.kind), e.cyc);
    end
  endfunction

  function void chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  // Monitor: report each output event in a fixed per-cycle order.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (lvl_a && !prev_a) got_ev(0, K_UP);
      if (!lvl_a && prev_a) got_ev(0, K_DN);
      if (press_a)          got_ev(0, K_PRESS);
      if (rpt_a)            got_ev(0, K_RPT);
      if (rel_a)            got_ev(0, K_REL);
      if (lvl_r && !prev_r) got_ev(1, K_UP);
      if (!lvl_r && prev_r) got_ev(1, K_DN);
      if (press_r)          got_ev(1, K_PRESS);
      if (rpt_r)            got_ev(1, K_RPT);
      if (rel_r)            got_ev(1, K_REL);
      prev_a = lvl_a;
      prev_r = lvl_r;
    end
  end

  task automatic expect_press(input int inst, input int c);
    expect_ev(inst, c, K_UP);
    expect_ev(inst, c, K_PRESS);
  endtask

  task automatic expect_release(input int inst, input int c);
    expect_ev(inst, c, K_DN);
    expect_ev(inst, c, K_REL);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b;
    int rpt_off[5];
    rpt_off = '{17, 22, 27, 32, 37};

    // 1: reset held with button pressed; press follows reset release
    rst_n = 1'b0;
    btn_a = 1'b1;
    btn_r = 1'b0;
    idle(3);
    chk("reset_level",   int'(lvl_a),   0);
    chk("reset_press",   int'(press_a), 0);
    chk("reset_repeat",  int'(rpt_a),   0);
    chk("reset_release", int'(rel_a),   0);
    chk("reset_level_r", int'(lvl_r),   0);
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    expect_press(0, b + 7);
    idle(10);
    btn_a = 1'b0;
    expect_release(0, cyc + 7);
    idle(12);

    // 3: short 3-cycle pulse is rejected
    btn_a = 1'b1;
    idle(3);
    btn_a = 1'b0;
    idle(12);
    chk("glitch_level", int'(lvl_a), 0);

    // 2: 20-cycle press then release
    btn_a = 1'b1;
    b = cyc;
    expect_press(0, b + 7);
    idle(20);
    btn_a = 1'b0;
    expect_release(0, b + 27);
    idle(12);

    // 4: 2-cycle drop mid-hold is absorbed
    btn_a = 1'b1;
    b = cyc;
    expect_press(0, b + 7);
    idle(12);
    btn_a = 1'b0;
    idle(2);
    btn_a = 1'b1;
    idle(6);
    chk("hold_glitch_level", int'(lvl_a), 1);
    idle(4);
    btn_a = 1'b0;
    expect_release(0, b + 31);
    idle(12);

    // 5: auto-repeat, delay 10, period 5, held 38 cycles
    btn_r = 1'b1;
    b = cyc;
    expect_press(1, b + 7);
    for (int i = 0; i < 5; i++) begin
      expect_ev(1, b + rpt_off[i], K_PRESS);
      expect_ev(1, b + rpt_off[i], K_RPT);
    end
    idle(38);
    btn_r = 1'b0;
    expect_release(1, b + 45);
    idle(12);

    // 6: reset during hold clears outputs without a release
    btn_a = 1'b1;
    b = cyc;
    expect_press(0, b + 7);
    idle(20);
    #5 rst_n = 1'b0;
    #1;
    chk("midhold_reset_level",   int'(lvl_a),   0);
    chk("midhold_reset_press",   int'(press_a), 0);
    chk("midhold_reset_repeat",  int'(rpt_a),   0);
    chk("midhold_reset_release", int'(rel_a),   0);
    idle(2);
    rst_n = 1'b1;
    b = cyc;
    expect_press(0, b + 7);
    idle(10);
    btn_a = 1'b0;
    expect_release(0, cyc + 7);
    idle(12);

    // Every queued event must have been observed.
    chk("pending_events_a", q_a.size(), 0);
    chk("pending_events_r", q_r.size(), 0);
    foreach (q_a[i]) $display("FAIL missing_event inst0: %s at cycle %0d never seen", kname(q_a[i].kind), q_a[i].cyc);
    foreach (q_r[i]) $display("FAIL missing_event inst1: %s at cycle %0d never seen", kname(q_r[i].kind), q_r[i].cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
